// File: rtl/vx_exe_issue_arbiter.sv
// vx_exe_issue_arbiter
// Round-robin arbiter that funnels NUM_REQS issue-slot dispatch streams into
// one execute-unit input through a single registered output stage. The output
// beat carries the index of the slot that produced it.
// Optional build macro: VX_EXE_ARB_PERF_EN adds 32-bit stall/grant counters.

module vx_exe_issue_arbiter #(
  parameter  int NUM_REQS = 4,
  parameter  int DATAW    = 64,
  localparam int TAGW     = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQS-1:0]       in_valid,
  input  logic [NUM_REQS*DATAW-1:0] in_data,
  output logic [NUM_REQS-1:0]       in_ready,
  output logic                      out_valid,
  output logic [DATAW-1:0]          out_data,
  output logic [TAGW-1:0]           out_tag,
  input  logic                      out_ready
`ifdef VX_EXE_ARB_PERF_EN
  ,
  output logic [31:0]               perf_stall_cycles,
  output logic [31:0]               perf_grants
`endif
);

  // Slot visited at position k of the rotated scan starting at base.
  function automatic logic [TAGW-1:0] rot_idx(input logic [TAGW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_REQS) begin
      s = s - NUM_REQS;
    end else begin
      s = s;
    end
    return TAGW'(s);
  endfunction

  logic                 out_valid_r;
  logic [DATAW-1:0]     out_data_r;
  logic [TAGW-1:0]      out_tag_r;
  logic [TAGW-1:0]      ptr_r;

  logic                 en_s;
  logic                 grant_valid_s;
  logic [TAGW-1:0]      grant_idx_s;
  logic [TAGW-1:0]      ptr_next_s;
  logic [NUM_REQS-1:0]  in_ready_s;

  // The stage can take a new beat when empty or when its current beat retires.
  assign en_s = !out_valid_r || out_ready;

  // Rotated priority scan: first valid slot at or after the pointer wins.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_idx_s   = '0;
    for (int k = 0; k < NUM_REQS; k++) begin
      if (!grant_valid_s && in_valid[rot_idx(ptr_r, k)]) begin
        grant_valid_s = 1'b1;
        grant_idx_s   = rot_idx(ptr_r, k);
      end else begin
        grant_valid_s = grant_valid_s;
      end
    end
  end

  // One-hot accept for the winner; nothing accepted while stalled or in reset.
  always_comb begin
    in_ready_s = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (!reset && en_s && grant_valid_s && (grant_idx_s == TAGW'(i))) begin
        in_ready_s[i] = 1'b1;
      end else begin
        in_ready_s[i] = 1'b0;
      end
    end
  end

  // Pointer moves to the slot just after the winner, wrapping to zero.
  always_comb begin
    if (grant_idx_s == TAGW'(NUM_REQS - 1)) begin
      ptr_next_s = '0;
    end else begin
      ptr_next_s = grant_idx_s + TAGW'(1);
    end
  end

  // Output register and priority pointer; a reset discards any held beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_tag_r   <= '0;
      ptr_r       <= '0;
    end else if (en_s) begin
      if (grant_valid_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= in_data[grant_idx_s*DATAW +: DATAW];
        out_tag_r   <= grant_idx_s;
        ptr_r       <= ptr_next_s;
      end else begin
        out_valid_r <= 1'b0;
      end
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_tag   = out_tag_r;

`ifdef VX_EXE_ARB_PERF_EN
  logic [31:0] perf_stall_r;
  logic [31:0] perf_grants_r;

  // Count cycles with pending requests blocked by a stalled output, and grants.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_stall_r  <= 32'd0;
      perf_grants_r <= 32'd0;
    end else begin
      if ((|in_valid) && !en_s) begin
        perf_stall_r <= perf_stall_r + 32'd1;
      end
      if (en_s && grant_valid_s) begin
        perf_grants_r <= perf_grants_r + 32'd1;
      end
    end
  end

  assign perf_stall_cycles = perf_stall_r;
  assign perf_grants       = perf_grants_r;
`endif

endmodule

// File: tb/tb_vx_exe_issue_arbiter.sv
// Directed bench for vx_exe_issue_arbiter: a 4-slot instance plus a 1-slot
// pass-through instance. Inputs change 1 time unit after the rising edge;
// outputs are checked 1 time unit after the edge or just before it.

module tb_vx_exe_issue_arbiter;

  localparam int N  = 4;
  localparam int W  = 64;
  localparam int W1 = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [1:0]     out_tag;
  logic           out_ready;

  logic           v1;
  logic [W1-1:0]  d1;
  logic           i1r;
  logic           o1v;
  logic [W1-1:0]  o1d;
  logic [0:0]     o1t;
  logic           r1;

`ifdef VX_EXE_ARB_PERF_EN
  logic [31:0] ps, pg, ps1, pg1;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  vx_exe_issue_arbiter #(.NUM_REQS(N), .DATAW(W)) dut (
    .clk(clk), .reset(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_tag(out_tag), .out_ready(out_ready)
`ifdef VX_EXE_ARB_PERF_EN
    , .perf_stall_cycles(ps), .perf_grants(pg)
`endif
  );

  vx_exe_issue_arbiter #(.NUM_REQS(1), .DATAW(W1)) dut1 (
    .clk(clk), .reset(rst), .in_valid(v1), .in_data(d1), .in_ready(i1r),
    .out_valid(o1v), .out_data(o1d), .out_tag(o1t), .out_ready(r1)
`ifdef VX_EXE_ARB_PERF_EN
    , .perf_stall_cycles(ps1), .perf_grants(pg1)
`endif
  );

  function automatic logic [W-1:0] mk(input int s, input int q);
    return {8'(s), 56'(q)};
  endfunction

  task automatic set_slot(input int s, input logic [W-1:0] d);
    in_data[s*W +: W] = d;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = '0; in_data = '0; out_ready = 1'b0;
    v1 = 1'b0; d1 = '0; r1 = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
    for (int s = 0; s < N; s++) set_slot(s, mk(s, 1));
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got %0b want 0", out_valid); end
    n_cmp++; if (out_data !== 64'd0) begin n_err++; $display("FAIL rst_out_data got %h want 0", out_data); end
    n_cmp++; if (out_tag !== 2'd0) begin n_err++; $display("FAIL rst_out_tag got %0d want 0", out_tag); end
    n_cmp++; if (in_ready !== 4'b0000) begin n_err++; $display("FAIL rst_in_ready got %b want 0000", in_ready); end
`ifdef VX_EXE_ARB_PERF_EN
    n_cmp++; if (ps !== 32'd0 || pg !== 32'd0) begin n_err++; $display("FAIL rst_perf got %0d/%0d want 0/0", ps, pg); end
`endif
    rst = 1'b0; in_valid = 4'b0001;
    #1;
    n_cmp++; if (in_ready !== 4'b0001) begin n_err++; $display("FAIL rst_first_ready got %b want 0001", in_ready); end
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL rst_load_valid got %0b want 1", out_valid); end
    out_ready = 1'b0; set_slot(0, mk(0, 2));
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b1 || out_data !== mk(0, 1)) begin n_err++; $display("FAIL rst_stall_hold got %0b/%h want 1/%h", out_valid, out_data, mk(0, 1)); end
    #2; rst = 1'b1; #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_async_clear got %0b want 0", out_valid); end
    n_cmp++; if (in_ready !== 4'b0000) begin n_err++; $display("FAIL rst_async_ready got %b want 0000", in_ready); end
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 4'hF; out_ready = 1'b1;
    for (int s = 0; s < N; s++) set_slot(s, mk(s, 3));
    #1;
    n_cmp++; if (in_ready !== 4'b0001) begin n_err++; $display("FAIL rst_release_ready got %b want 0001", in_ready); end
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b1 || out_tag !== 2'd0) begin n_err++; $display("FAIL rst_release_tag got %0b/%0d want 1/0", out_valid, out_tag); end
  endtask

  task automatic test_round_robin();
    int e;
    do_reset();
    in_valid = 4'hF; out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      e = k % N;
      for (int s = 0; s < N; s++) set_slot(s, mk(s, 10 + k));
      #1;
      n_cmp++; if (in_ready !== 4'(1 << e)) begin n_err++; $display("FAIL rr_ready k=%0d got %b want %b", k, in_ready, 4'(1 << e)); end
      @(posedge clk); #1;
      n_cmp++; if (out_valid !== 1'b1 || out_tag !== 2'(e) || out_data !== mk(e, 10 + k)) begin
        n_err++; $display("FAIL rr_out k=%0d got %0b/%0d/%h want 1/%0d/%h", k, out_valid, out_tag, out_data, e, mk(e, 10 + k));
      end
    end
  endtask

  task automatic test_skip_wrap();
    int exp_g [3] = '{0, 2, 0};
    do_reset();
    out_ready = 1'b1; in_valid = 4'b0100; set_slot(2, mk(2, 20));
    #1;
    n_cmp++; if (in_ready !== 4'b0100) begin n_err++; $display("FAIL sw_pre_ready got %b want 0100", in_ready); end
    @(posedge clk); #1;
    n_cmp++; if (out_tag !== 2'd2) begin n_err++; $display("FAIL sw_pre_tag got %0d want 2", out_tag); end
    in_valid = 4'b0101;
    for (int j = 0; j < 3; j++) begin
      for (int s = 0; s < N; s++) set_slot(s, mk(s, 21 + j));
      #1;
      n_cmp++; if (in_ready !== 4'(1 << exp_g[j])) begin n_err++; $display("FAIL sw_ready j=%0d got %b want %b", j, in_ready, 4'(1 << exp_g[j])); end
      @(posedge clk); #1;
      n_cmp++; if (out_tag !== 2'(exp_g[j]) || out_data !== mk(exp_g[j], 21 + j)) begin
        n_err++; $display("FAIL sw_out j=%0d got %0d/%h want %0d/%h", j, out_tag, out_data, exp_g[j], mk(exp_g[j], 21 + j));
      end
    end
  endtask

  task automatic test_back_pressure();
    do_reset();
    in_valid = 4'b0011; set_slot(0, mk(0, 30)); set_slot(1, mk(1, 30)); out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 4'b0001) begin n_err++; $display("FAIL bp_first_ready got %b want 0001", in_ready); end
    @(posedge clk); #1;
    n_cmp++; if (out_tag !== 2'd0 || out_data !== mk(0, 30)) begin n_err++; $display("FAIL bp_first_out got %0d/%h want 0/%h", out_tag, out_data, mk(0, 30)); end
    set_slot(0, mk(0, 31)); out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_cmp++; if (in_ready !== 4'b0000) begin n_err++; $display("FAIL bp_stall_ready c=%0d got %b want 0000", c, in_ready); end
      @(posedge clk); #1;
      n_cmp++; if (out_valid !== 1'b1 || out_tag !== 2'd0 || out_data !== mk(0, 30)) begin
        n_err++; $display("FAIL bp_stall_out c=%0d got %0b/%0d/%h want 1/0/%h", c, out_valid, out_tag, out_data, mk(0, 30));
      end
    end
`ifdef VX_EXE_ARB_PERF_EN
    n_cmp++; if (ps !== 32'd5) begin n_err++; $display("FAIL bp_perf_stall got %0d want 5", ps); end
`endif
    out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 4'b0010) begin n_err++; $display("FAIL bp_release_ready got %b want 0010", in_ready); end
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b1 || out_tag !== 2'd1 || out_data !== mk(1, 30)) begin
      n_err++; $display("FAIL bp_release_out got %0b/%0d/%h want 1/1/%h", out_valid, out_tag, out_data, mk(1, 30));
    end
`ifdef VX_EXE_ARB_PERF_EN
    n_cmp++; if (pg !== 32'd2 || ps !== 32'd5) begin n_err++; $display("FAIL bp_perf_final got %0d/%0d want 2/5", pg, ps); end
`endif
  endtask

  task automatic test_payload();
    logic [W+1:0] exp_q [$];
    logic [W+1:0] got;
    logic [W+1:0] want;
    logic [N-1:0] hs;
    int seq [N];
    int n_out;
    do_reset();
    for (int s = 0; s < N; s++) seq[s] = 0;
    n_out = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int s = 0; s < N; s++) begin
        if (!in_valid[s] && ($urandom_range(0, 1) == 1)) begin
          in_valid[s] = 1'b1; set_slot(s, mk(s, seq[s]));
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      hs = in_valid & in_ready;
      n_cmp++; if ($countones(in_ready) > 1) begin n_err++; $display("FAIL pl_onehot cyc=%0d got %b want one-hot or zero", cyc, in_ready); end
      if (out_valid && !out_ready) begin
        n_cmp++; if (in_ready !== 4'b0000) begin n_err++; $display("FAIL pl_stall_ready cyc=%0d got %b want 0000", cyc, in_ready); end
      end
      if (out_valid && out_ready) begin
        got = {out_tag, out_data};
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL pl_spurious cyc=%0d got %h want no beat", cyc, got);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin n_err++; $display("FAIL pl_beat cyc=%0d got %h want %h", cyc, got, want); end
          n_out++;
        end
      end
      for (int s = 0; s < N; s++) begin
        if (hs[s]) exp_q.push_back({2'(s), in_data[s*W +: W]});
      end
      @(posedge clk); #1;
      for (int s = 0; s < N; s++) begin
        if (hs[s]) begin
          seq[s]++;
          if ($urandom_range(0, 1) == 1) set_slot(s, mk(s, seq[s]));
          else in_valid[s] = 1'b0;
        end
      end
    end
    in_valid = '0; out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (out_valid) begin
        got = {out_tag, out_data};
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL pl_drain_spurious got %h want no beat", got);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin n_err++; $display("FAIL pl_drain_beat got %h want %h", got, want); end
          n_out++;
        end
      end
      @(posedge clk); #1;
    end
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL pl_lost got %0d pending want 0", exp_q.size()); end
    n_cmp++; if (n_out < 100) begin n_err++; $display("FAIL pl_volume got %0d beats want >=100", n_out); end
  endtask

  task automatic test_single();
    do_reset();
    v1 = 1'b1; d1 = 16'h1111; r1 = 1'b1;
    #1;
    n_cmp++; if (i1r !== 1'b1) begin n_err++; $display("FAIL s1_ready_a got %0b want 1", i1r); end
    @(posedge clk); #1;
    n_cmp++; if (o1v !== 1'b1 || o1d !== 16'h1111 || o1t !== 1'b0) begin n_err++; $display("FAIL s1_out_a got %0b/%h/%0d want 1/1111/0", o1v, o1d, o1t); end
    d1 = 16'h2222; r1 = 1'b0;
    #1;
    n_cmp++; if (i1r !== 1'b0) begin n_err++; $display("FAIL s1_ready_b got %0b want 0", i1r); end
    @(posedge clk); #1;
    n_cmp++; if (o1v !== 1'b1 || o1d !== 16'h1111) begin n_err++; $display("FAIL s1_out_b got %0b/%h want 1/1111", o1v, o1d); end
    r1 = 1'b1;
    #1;
    n_cmp++; if (i1r !== 1'b1) begin n_err++; $display("FAIL s1_ready_c got %0b want 1", i1r); end
    @(posedge clk); #1;
    n_cmp++; if (o1v !== 1'b1 || o1d !== 16'h2222 || o1t !== 1'b0) begin n_err++; $display("FAIL s1_out_c got %0b/%h/%0d want 1/2222/0", o1v, o1d, o1t); end
`ifdef VX_EXE_ARB_PERF_EN
    n_cmp++; if (pg1 !== 32'd2) begin n_err++; $display("FAIL s1_perf_grants got %0d want 2", pg1); end
`endif
    v1 = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (o1v !== 1'b0) begin n_err++; $display("FAIL s1_drain got %0b want 0", o1v); end
  endtask

  initial begin
    rst = 1'b1; in_valid = '0; in_data = '0; out_ready = 1'b0;
    v1 = 1'b0; d1 = '0; r1 = 1'b0;
    test_reset();
    test_round_robin();
    test_skip_wrap();
    test_back_pressure();
    test_payload();
    test_single();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
